// File: rtl/fnd_bcd_converter.sv
// fnd_bcd_converter: iterative binary-to-BCD converter for the FND display path.
// A shift-add-3 (double-dabble) engine converts the 14-bit FDR value into four
// packed BCD digits over a fixed 15-cycle conversion, then holds the result
// stable for the digit-scan logic until the next conversion completes.
// Optional build macro: FND_BCD_SATURATE_EN -- when defined, values above 9999
// present as 16'h9999 instead of wrapping modulo 10000.

module fnd_bcd_converter #(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    // One spare digit of scratch so values up to 16383 convert without loss;
    // the top digit is what tells us the value exceeded the displayable range.
    localparam int SCR_W = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(IN_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [IN_W-1:0]    shift_reg;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_adj;
    logic [4*DIGITS-1:0] result;
    logic               overflow_next;
    logic               last_step;

    assign last_step = (count == CNT_W'(IN_W - 1));
    assign busy      = (state != IDLE);

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept a start only when idle, run a fixed number of steps.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_step) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction: any digit >= 5 would carry incorrectly after doubling.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i <= DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Final digit selection: the ten-thousands digit flags overflow and is dropped.
    always_comb begin
        overflow_next = |scratch[SCR_W-1 -: 4];
`ifdef FND_BCD_SATURATE_EN
        result = overflow_next ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
`else
        result = scratch[4*DIGITS-1:0];
`endif
    end

    // Conversion datapath: load on accepted start, shift one bit per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        count     <= '0;
                    end
                end
                SHIFT: begin
                    {scratch, shift_reg} <= {scratch_adj, shift_reg} << 1;
                    if (!last_step) begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output registers: only the finished result is ever exposed to the scan logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_out  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == FINISH);
            if (state == FINISH) begin
                bcd_out  <= result;
                overflow <= overflow_next;
            end
        end
    end

endmodule

// File: tb/tb_fnd_bcd_converter.sv
// tb_fnd_bcd_converter: self-checking bench for the FND binary-to-BCD converter.
// Expected digits come from plain decimal arithmetic on the input value.

module tb_fnd_bcd_converter;

    logic        clk;
    logic        rst;
    logic [13:0] bin_in;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int checks;
    int errors;

    fnd_bcd_converter #(.IN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bin_in   (bin_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: decimal digits of the value, wrapped or saturated above 9999.
    function automatic logic [15:0] model_bcd(input int v);
        int w;
`ifdef FND_BCD_SATURATE_EN
        if (v > 9999) return 16'h9999;
`endif
        w = v % 10000;
        return {4'(w / 1000), 4'((w / 100) % 10), 4'((w / 10) % 10), 4'(w % 10)};
    endfunction

    function automatic logic model_ovf(input int v);
        return (v > 9999);
    endfunction

    function automatic logic nibbles_legal(input logic [15:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    // Start one conversion from idle and wait (bounded) for done.
    task automatic applyStimulus(input int value, output int latency, output int busy_cycles);
        @(negedge clk);
        bin_in = 14'(value);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = 14'($urandom);
        latency     = 0;
        busy_cycles = 0;
        while (latency < 40 && !done) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic runConvert(input int value, input string tag);
        int lat;
        int bc;
        applyStimulus(value, lat, bc);
        checkOutput({tag, " latency"}, lat, 15);
        checkOutput({tag, " busy_cycles"}, bc, 15);
        checkOutput({tag, " busy_at_done"}, busy, 1'b0);
        checkOutput({tag, " bcd"}, bcd_out, model_bcd(value));
        checkOutput({tag, " overflow"}, overflow, model_ovf(value));
        checkOutput({tag, " legal"}, nibbles_legal(bcd_out), 1'b1);
        @(posedge clk);
        #1;
        checkOutput({tag, " done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        int done_count;
        int v;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset bcd", bcd_out, 16'h0000);
        checkOutput("reset overflow", overflow, 1'b0);
        rst = 1'b0;

        // Basic conversion
        runConvert(1234, "conv1234");

        // Back-to-back with start held high: 0 then 9999
        @(negedge clk);
        bin_in = 14'd0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        bin_in = 14'd9999;
        lat = 0;
        while (lat < 40 && !done) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("b2b first latency", lat, 15);
        checkOutput("b2b first bcd", bcd_out, 16'h0000);
        checkOutput("b2b first overflow", overflow, 1'b0);
        checkOutput("b2b idle at done", busy, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("b2b second accepted", busy, 1'b1);
        lat = 0;
        while (lat < 40 && !done) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        checkOutput("b2b second latency", lat, 15);
        checkOutput("b2b second bcd", bcd_out, 16'h9999);
        checkOutput("b2b second overflow", overflow, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("b2b no third", busy, 1'b0);

        // Overflow boundaries
        runConvert(16383, "conv16383");
        runConvert(10000, "conv10000");
        runConvert(9999, "conv9999");

        // Start while busy is ignored; bin_in changes have no effect
        @(negedge clk);
        bin_in = 14'd5678;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = 14'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd1111;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = 14'd2222;
        lat = 3;
        while (lat < 40 && !done) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("ignore latency", lat, 15);
        checkOutput("ignore bcd", bcd_out, 16'h5678);
        done_count = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) done_count++;
        end
        checkOutput("ignore no second done", done_count, 0);
        checkOutput("ignore idle", busy, 1'b0);

        // Reset mid-conversion
        runConvert(4321, "conv4321");
        @(negedge clk);
        bin_in = 14'd8765;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort done", done, 1'b0);
        checkOutput("abort bcd", bcd_out, 16'h0000);
        checkOutput("abort overflow", overflow, 1'b0);
        done_count = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) done_count++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) done_count++;
        end
        checkOutput("abort no done", done_count, 0);
        checkOutput("abort bcd held", bcd_out, 16'h0000);
        runConvert(42, "conv42");

        // Randomized sweep
        for (int n = 0; n < 24; n++) begin
            v = int'($urandom_range(0, 16383));
            $display("[TB] random value %0d", v);
            runConvert(v, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
